oled_char_scheduler: RTL and testbench
======================================

OLED_CHAR_SCHEDULER -- requirements
Module: oled_char_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: character queue depth; power of two, at least 2.
REQ-002 Parameter GAP_CYCLES, default 1000: idle clk cycles inserted after each accepted character; 0 means no gap.
REQ-003 Parameter COLS, default 16: text columns per page (8x8 font on 128-pixel width).
REQ-004 Parameter PAGES, default 8: text pages (rows).
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 wr_data  in  8  character code to enqueue.
REQ-008 wr_en  in  1  enqueue strobe, one character per cycle.
REQ-009 full  out  1  queue holds FIFO_DEPTH entries.
REQ-010 count  out  log2(FIFO_DEPTH)+1  current queue occupancy.
REQ-011 overflow  out  1  sticky flag: a write was dropped.
REQ-012 char_out  out  8  printable character presented to the OLED driver.
REQ-013 col_out  out  log2(COLS)  target column for char_out.
REQ-014 page_out  out  log2(PAGES)  target page for char_out.
REQ-015 char_valid  out  1  char_out, col_out and page_out are valid.
REQ-016 char_ack  in  1  driver accepts the current character.
REQ-017 clear_req  out  1  request to the driver for a full-screen clear.
REQ-018 clear_ack  in  1  driver has completed the clear.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 The queue shall be a synchronous FIFO.
REQ-021 A write with wr_en=1 and full=0 shall be stored at that rising edge.
REQ-022 A write with wr_en=1 and full=1 shall be dropped and shall set overflow, which stays set until reset.
REQ-023 full shall be evaluated before any same-cycle pop, so a simultaneous write and pop while full drops the write.
REQ-024 The FSM states shall be IDLE, DECODE, ISSUE, CLEAR and GAP.
REQ-025 IDLE, queue non-empty: pop the head into cur_char and go to DECODE.
REQ-026 DECODE, code 0x20..0x7E: go to ISSUE, with char_valid registered high at the transition edge.
REQ-027 DECODE, code 0x0A: set col=0, set page=(page+1) mod PAGES, go to IDLE; no driver transaction.
REQ-028 DECODE, code 0x0D: set col=0, go to IDLE; no driver transaction.
REQ-029 DECODE, code 0x0C: go to CLEAR.
REQ-030 DECODE, any other code: discard the character and go to IDLE.
REQ-031 ISSUE: hold char_valid=1 and keep char_out, col_out and page_out stable until char_ack=1 is sampled.
REQ-032 The transfer shall occur on the edge where char_valid=1 and char_ack=1; char_valid shall be low in the next cycle.
REQ-033 On a transfer, col shall increment; col=COLS-1 wraps to 0 and advances page, and page=PAGES-1 wraps to 0.
REQ-034 After a transfer: go to GAP when GAP_CYCLES>0, otherwise go to IDLE.
REQ-035 GAP shall count exactly GAP_CYCLES cycles, then go to IDLE.
REQ-036 CLEAR: hold clear_req=1 until clear_ack=1 is sampled.
REQ-037 When CLEAR completes: set col=0 and page=0, deassert clear_req the next cycle, and go to IDLE.
REQ-038 char_ack outside ISSUE and clear_ack outside CLEAR shall be ignored.
REQ-039 Latency: a printable character written at edge N into an empty queue, with the FSM in IDLE, shall have char_valid=1 after edge N+2.
REQ-040 Enqueue shall continue in every FSM state.

Reset
REQ-041 rst=1 shall immediately clear the FIFO pointers, count, overflow, col, page, char_valid, clear_req, busy and the gap counter, and set char_out=0x00 and state=IDLE.
REQ-042 Reset asserted during ISSUE or CLEAR shall abort the transaction, and the aborted character shall not be re-issued.
REQ-043 Release of rst shall be synchronised with a two-flop release stage so that all flops leave reset on the same edge.

Verification
REQ-044 Write "HELLO" with char_ack tied 1 and GAP_CYCLES=4: five transfers at col 0..4, page 0, at least 5 cycles apart, and char_valid first high 2 edges after the first write.
REQ-045 Write 17 printable characters with COLS=16: the 17th is issued at col 0, page 1; after 8*16 characters, page wraps to 0.
REQ-046 Hold char_ack=0 and write 20 characters with FIFO_DEPTH=16: full=1, overflow=1, count=16, char_out stable, and only the queued characters are later issued.
REQ-047 Write 0x0C with clear_ack delayed 10 cycles: clear_req is high for 10 cycles, then col=0 and page=0, and no char_valid pulse occurs.
REQ-048 Write "A",0x0A,"B",0x0D,"C",0x07: A at (0,0), B at (0,1), C at (0,1), and 0x07 is dropped with no transaction.
REQ-049 Assert rst mid-ISSUE: all outputs go to their reset values within the same cycle, and the next written character is issued at (0,0).

Source files
------------

// File: rtl/oled_char_scheduler_if.sv
// Character-write and OLED-driver handshake bundle for oled_char_scheduler.
interface oled_char_scheduler_if #(
    parameter int FIFO_DEPTH = 16,
    parameter int COLS       = 16,
    parameter int PAGES      = 8
);
    logic [7:0]                    wr_data;
    logic                          wr_en;
    logic                          full;
    logic [$clog2(FIFO_DEPTH):0]   count;
    logic                          overflow;
    logic [7:0]                    char_out;
    logic [$clog2(COLS)-1:0]       col_out;
    logic [$clog2(PAGES)-1:0]      page_out;
    logic                          char_valid;
    logic                          char_ack;
    logic                          clear_req;
    logic                          clear_ack;
    logic                          busy;

    modport master (
        output wr_data, wr_en, char_ack, clear_ack,
        input  full, count, overflow, char_out, col_out, page_out,
        input  char_valid, clear_req, busy
    );

    modport slave (
        input  wr_data, wr_en, char_ack, clear_ack,
        output full, count, overflow, char_out, col_out, page_out,
        output char_valid, clear_req, busy
    );
endinterface

// File: rtl/oled_char_scheduler.sv
// Queues character codes and feeds printable ones to an OLED text driver,
// tracking the cursor and handling newline, carriage return and form feed.
module oled_char_scheduler #(
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_CYCLES = 1000,
    parameter int COLS       = 16,
    parameter int PAGES      = 8
) (
    input logic                  clk,
    input logic                  rst,
    oled_char_scheduler_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);
    localparam int GW = $clog2(GAP_CYCLES + 2);

    typedef enum logic [2:0] {
        IDLE, DECODE, ISSUE, CLEAR, GAP
    } state_t;

    // Asserts asynchronously, releases on the second clean edge.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_i;

    assign rst_sync_d = {rst_sync_q[0], 1'b0};
    assign rst_i      = rst_sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_sync_q <= 2'b11;
        else     rst_sync_q <= rst_sync_d;
    end

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full, empty, push, pop;

    state_t        state_q, state_d;
    logic [7:0]    char_q, char_d;
    logic [CW-1:0] col_q, col_d;
    logic [PW-1:0] page_q, page_d;
    logic          valid_q, valid_d;
    logic          clr_q, clr_d;
    logic          busy_q, busy_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          is_print;

    assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.wr_en && !full;
    assign pop   = (state_q == IDLE) && !empty;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        overflow_d = overflow_q | (bus.wr_en & full);
    end

    function automatic logic [PW-1:0] next_page(input logic [PW-1:0] p);
        return (p == PW'(PAGES - 1)) ? '0 : p + PW'(1);
    endfunction

    assign is_print = (char_q >= 8'h20) && (char_q <= 8'h7E);

    always_comb begin
        state_d = state_q;
        char_d  = char_q;
        col_d   = col_q;
        page_d  = page_q;
        valid_d = valid_q;
        clr_d   = clr_q;
        gap_d   = gap_q;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    char_d  = mem_q[rd_ptr_q];
                    state_d = DECODE;
                end
            end
            DECODE: begin
                unique case (1'b1)
                    is_print: begin
                        valid_d = 1'b1;
                        state_d = ISSUE;
                    end
                    (char_q == 8'h0A): begin
                        col_d   = '0;
                        page_d  = next_page(page_q);
                        state_d = IDLE;
                    end
                    (char_q == 8'h0D): begin
                        col_d   = '0;
                        state_d = IDLE;
                    end
                    (char_q == 8'h0C): begin
                        clr_d   = 1'b1;
                        state_d = CLEAR;
                    end
                    default: state_d = IDLE;
                endcase
            end
            ISSUE: begin
                if (bus.char_ack) begin
                    valid_d = 1'b0;
                    gap_d   = '0;
                    if (col_q == CW'(COLS - 1)) begin
                        col_d  = '0;
                        page_d = next_page(page_q);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            CLEAR: begin
                if (bus.clear_ack) begin
                    clr_d   = 1'b0;
                    col_d   = '0;
                    page_d  = '0;
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
                else                              gap_d   = gap_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            char_q     <= 8'h00;
            col_q      <= '0;
            page_q     <= '0;
            valid_q    <= 1'b0;
            clr_q      <= 1'b0;
            busy_q     <= 1'b0;
            gap_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            char_q     <= char_d;
            col_q      <= col_d;
            page_q     <= page_d;
            valid_q    <= valid_d;
            clr_q      <= clr_d;
            busy_q     <= busy_d;
            gap_q      <= gap_d;
        end
    end

    assign bus.full       = full;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.char_out   = char_q;
    assign bus.col_out    = col_q;
    assign bus.page_out   = page_q;
    assign bus.char_valid = valid_q;
    assign bus.clear_req  = clr_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_oled_char_scheduler.sv
// Directed vector bench for oled_char_scheduler: cursor handling, gap timing,
// overflow, clear handshake and reset abort.
module tb_oled_char_scheduler;
    localparam int FD  = 16;
    localparam int GAP = 4;
    localparam int NC  = 16;
    localparam int NP  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oled_char_scheduler_if #(.FIFO_DEPTH(FD), .COLS(NC), .PAGES(NP)) bus();

    oled_char_scheduler #(
        .FIFO_DEPTH(FD), .GAP_CYCLES(GAP), .COLS(NC), .PAGES(NP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] ch;
        int         col;
        int         page;
        int         cyc;
    } xfer_t;

    typedef struct {
        logic [7:0] code;
        bit         issue;
        logic [7:0] ch;
        int         col;
        int         page;
    } vec_t;

    xfer_t xq[$];
    int    cyc   = 0;
    int    vcnt  = 0;
    int    total = 0;
    int    passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.char_valid) begin
            vcnt <= vcnt + 1;
            if (bus.char_ack)
                xq.push_back('{bus.char_out, int'(bus.col_out),
                               int'(bus.page_out), cyc});
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic wr(input logic [7:0] c);
        bus.wr_data = c;
        bus.wr_en   = 1'b1;
        @(posedge clk); #1;
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        repeat (2) @(posedge clk);
        #1;
        while ((bus.busy || bus.count != 0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_idle"}, int'(n < 400), 1);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!bus.char_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_valid"}, int'(n < 20), 1);
    endtask

    vec_t       tbl [12];
    logic [7:0] hello [5];
    int         n0, wc, v0, hi, got;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.wr_data   = 8'h00;
        bus.wr_en     = 1'b0;
        bus.char_ack  = 1'b0;
        bus.clear_ack = 1'b0;
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        tbl[0]  = '{8'h41, 1'b1, 8'h41, 0, 0};
        tbl[1]  = '{8'h0A, 1'b0, 8'h00, 0, 0};
        tbl[2]  = '{8'h42, 1'b1, 8'h42, 0, 1};
        tbl[3]  = '{8'h0D, 1'b0, 8'h00, 0, 0};
        tbl[4]  = '{8'h43, 1'b1, 8'h43, 0, 1};
        tbl[5]  = '{8'h07, 1'b0, 8'h00, 0, 0};
        tbl[6]  = '{8'h20, 1'b1, 8'h20, 1, 1};
        tbl[7]  = '{8'h7E, 1'b1, 8'h7E, 2, 1};
        tbl[8]  = '{8'h7F, 1'b0, 8'h00, 0, 0};
        tbl[9]  = '{8'h1F, 1'b0, 8'h00, 0, 0};
        tbl[10] = '{8'h0A, 1'b0, 8'h00, 0, 0};
        tbl[11] = '{8'h21, 1'b1, 8'h21, 0, 2};

        #1;
        check("rst_valid", bus.char_valid, 0);
        check("rst_clear_req", bus.clear_req, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_count", bus.count, 0);
        check("rst_full", bus.full, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_char_out", bus.char_out, 0);
        check("rst_col", bus.col_out, 0);
        check("rst_page", bus.page_out, 0);
        do_reset();

        // "HELLO" with ack tied high
        bus.char_ack = 1'b1;
        n0 = xq.size();
        wc = 0;
        for (int i = 0; i < 5; i++) begin
            wr(hello[i]);
            if (i == 0) wc = cyc;
        end
        wait_idle("hello");
        got = xq.size() - n0;
        check("hello_n", got, 5);
        for (int i = 0; i < 5 && i < got; i++) begin
            check($sformatf("hello%0d_ch", i), xq[n0+i].ch, hello[i]);
            check($sformatf("hello%0d_col", i), xq[n0+i].col, i);
            check($sformatf("hello%0d_page", i), xq[n0+i].page, 0);
            if (i == 0)
                check("hello_latency", xq[n0].cyc - wc, 2);
            else
                check($sformatf("hello%0d_spacing", i),
                      xq[n0+i].cyc - xq[n0+i-1].cyc, GAP + 3);
        end

        // control codes and printable boundaries
        do_reset();
        for (int i = 0; i < 12; i++) begin
            n0 = xq.size();
            wr(tbl[i].code);
            wait_idle($sformatf("vec%0d", i));
            check($sformatf("vec%0d_n", i), xq.size() - n0, int'(tbl[i].issue));
            if (tbl[i].issue && xq.size() > n0) begin
                check($sformatf("vec%0d_ch", i), xq[$].ch, tbl[i].ch);
                check($sformatf("vec%0d_col", i), xq[$].col, tbl[i].col);
                check($sformatf("vec%0d_page", i), xq[$].page, tbl[i].page);
            end
        end

        // form feed with a slow clear_ack
        do_reset();
        wr(8'h58); wait_idle("ff_x");
        wr(8'h0A); wait_idle("ff_lf");
        wr(8'h59); wait_idle("ff_y");
        check("ff_pre_col", bus.col_out, 1);
        check("ff_pre_page", bus.page_out, 1);
        v0 = vcnt;
        bus.clear_ack = 1'b1;
        @(posedge clk); #1;
        bus.clear_ack = 1'b0;
        check("ff_stray_ack_page", bus.page_out, 1);
        wr(8'h0C);
        hi = 0;
        while (!bus.clear_req && hi < 10) begin
            @(posedge clk); #1;
            hi++;
        end
        check("ff_req_seen", bus.clear_req, 1);
        hi = 0;
        repeat (10) begin
            if (bus.clear_req) hi++;
            @(posedge clk); #1;
        end
        check("ff_req_cycles", hi, 10);
        bus.clear_ack = 1'b1;
        @(posedge clk); #1;
        bus.clear_ack = 1'b0;
        check("ff_req_drop", bus.clear_req, 0);
        check("ff_col", bus.col_out, 0);
        check("ff_page", bus.page_out, 0);
        check("ff_busy", bus.busy, 0);
        check("ff_no_valid", vcnt - v0, 0);

        // overflow with the driver stalled
        do_reset();
        bus.char_ack = 1'b0;
        n0 = xq.size();
        for (int i = 0; i < 20; i++) wr(8'h30 + 8'(i));
        check("ovf_full", bus.full, 1);
        check("ovf_flag", bus.overflow, 1);
        check("ovf_count", bus.count, FD);
        check("ovf_valid", bus.char_valid, 1);
        check("ovf_char", bus.char_out, 8'h30);
        repeat (5) @(posedge clk);
        #1;
        check("ovf_char_stable", bus.char_out, 8'h30);
        check("ovf_col_stable", bus.col_out, 0);
        bus.char_ack = 1'b1;
        wait_idle("ovf");
        got = xq.size() - n0;
        check("ovf_n", got, 17);
        for (int k = 0; k < 17 && k < got; k++)
            check($sformatf("ovf%0d_ch", k), xq[n0+k].ch, 8'h30 + k);
        check("ovf_sticky", bus.overflow, 1);
        check("ovf_not_full", bus.full, 0);

        // column and page wrap
        do_reset();
        for (int k = 0; k < 129; k++) begin
            wr(8'h41 + 8'(k % 26));
            wait_idle($sformatf("wrap%0d", k));
            if (k == 15 || k == 16 || k == 127 || k == 128) begin
                check($sformatf("wrap%0d_col", k), xq[$].col,
                      (k == 15 || k == 127) ? 15 : 0);
                check($sformatf("wrap%0d_page", k), xq[$].page,
                      (k == 16) ? 1 : ((k == 127) ? 7 : 0));
            end
        end

        // reset in the middle of ISSUE
        do_reset();
        bus.char_ack = 1'b1;
        wr(8'h50);
        wait_idle("mid_p");
        bus.char_ack = 1'b0;
        wr(8'h51);
        wait_valid("mid_q");
        n0 = xq.size();
        rst = 1'b1;
        #1;
        check("mid_valid", bus.char_valid, 0);
        check("mid_busy", bus.busy, 0);
        check("mid_char", bus.char_out, 0);
        check("mid_col", bus.col_out, 0);
        check("mid_page", bus.page_out, 0);
        check("mid_count", bus.count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.char_ack = 1'b1;
        wr(8'h53);
        wait_idle("mid_s");
        check("mid_n", xq.size() - n0, 1);
        check("mid_s_ch", xq[$].ch, 8'h53);
        check("mid_s_col", xq[$].col, 0);
        check("mid_s_page", xq[$].page, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
